// File: rtl/ldmstm_uop_sequencer_pkg.sv
// leg_uop_pkg: shared states, register-select constants and addressing-mode encodings
// for the LDM/STM micro-op sequencer.
package leg_uop_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, XFER, WB} state_t;
   localparam logic [3:0] RZ_SEL = 4'hF;
   localparam logic [3:0] PC_IDX = 4'hF;
   // {P,U} addressing modes
   localparam logic [1:0] MODE_DA = 2'b00;
   localparam logic [1:0] MODE_IA = 2'b01;
   localparam logic [1:0] MODE_DB = 2'b10;
   localparam logic [1:0] MODE_IB = 2'b11;
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int j = 0; j < 16; j++) c = c + 5'(v[j]);
      return c;
   endfunction
endpackage

// File: rtl/ldmstm_uop_sequencer_if.sv
// ldmstm_uop_sequencer_if: Decode-side instruction inputs and micro-op outputs
// of the sequencer; master is the pipeline, slave is the sequencer.
interface ldmstm_uop_sequencer_if;
   logic [31:0] InstrD;
   logic        ValidD;
   logic        StallD;
   logic        FlushD;
   logic [3:0]  RA1_4b_D;
   logic [3:0]  RA2_4b_D;
   logic [3:0]  DestRegD;
   logic [2:0]  RegFileRzD;
   logic [11:0] UopImmD;
   logic        UopAddD;
   logic        UopMemReadD;
   logic        UopMemWriteD;
   logic        UopRegWriteD;
   logic        UopActiveD;
   logic        uOpStallD;
   modport master (
      output InstrD, ValidD, StallD, FlushD,
      input  RA1_4b_D, RA2_4b_D, DestRegD, RegFileRzD, UopImmD, UopAddD,
             UopMemReadD, UopMemWriteD, UopRegWriteD, UopActiveD, uOpStallD
   );
   modport slave (
      input  InstrD, ValidD, StallD, FlushD,
      output RA1_4b_D, RA2_4b_D, DestRegD, RegFileRzD, UopImmD, UopAddD,
             UopMemReadD, UopMemWriteD, UopRegWriteD, UopActiveD, uOpStallD
   );
endinterface

// File: rtl/ldmstm_uop_sequencer_lsb.sv
// lowest_set_bit16: priority encoder giving the index of the lowest set bit of a 16-bit mask.
module lowest_set_bit16 (
   input  logic [15:0] i_mask,
   output logic [3:0]  o_idx,
   output logic        o_valid
);
   always_comb begin
      o_idx = '0;
      for (int j = 15; j >= 0; j--) if (i_mask[j]) o_idx = 4'(j);
   end
   assign o_valid = |i_mask;
endmodule

// File: rtl/ldmstm_uop_sequencer.sv
// ldmstm_uop_sequencer: expands LDM/STM into an address micro-op, one transfer per register
// and an optional base writeback; other instructions pass straight through.
module ldmstm_uop_sequencer
   import leg_uop_pkg::*;
#(
   parameter int WORD_BYTES = 4
) (
   input logic clk,
   input logic reset,
   ldmstm_uop_sequencer_if.slave bus
);
   state_t      r_state;
   logic [15:0] r_mask;
   logic [4:0]  r_idx, r_n;
   logic [3:0]  r_rn;
   logic        r_u, r_l, r_wb, r_early;
   logic [15:0] w_list, w_clr, w_m;
   logic [4:0]  w_n;
   logic [3:0]  w_rn, w_k;
   logic [1:0]  w_mode;
   logic        w_k_vld, w_blk, w_start, w_wb_i, w_early_i, w_wb, w_early, w_unused;
   logic [11:0] w_wbytes, w_imm_n, w_imm_start;
   state_t      w_adv, w_nxt;
   lowest_set_bit16 u_lsb (.i_mask(r_mask), .o_idx(w_k), .o_valid(w_k_vld));
   assign w_list    = bus.InstrD[15:0];
   assign w_rn      = bus.InstrD[19:16];
   assign w_mode    = bus.InstrD[24:23];
   assign w_n       = popcount16(w_list);
   assign w_blk     = bus.ValidD && bus.InstrD[27:25] == 3'b100;
   assign w_start   = r_state == IDLE && w_blk && w_n != 5'd0;
   // a load that includes the base leaves the loaded value in Rn, so no writeback
   assign w_wb_i    = bus.InstrD[21] && !(bus.InstrD[20] && w_list[w_rn]);
   assign w_early_i = w_wb_i && bus.InstrD[20] && w_list[PC_IDX];
   assign w_wb      = r_state == IDLE ? w_wb_i : r_wb;
   assign w_early   = r_state == IDLE ? w_early_i : r_early;
   assign w_clr     = r_mask & ~(16'd1 << w_k);
   assign w_m       = r_state == XFER ? w_clr : r_state == IDLE ? (w_start ? w_list : 16'd0) : r_mask;
   // early writeback slots in just before the PC load so the PC load stays last
   assign w_adv     = r_state == WB ? (w_m != 16'd0 ? XFER : IDLE)
                    : w_m == 16'd0 ? (w_wb && !w_early ? WB : IDLE)
                    : (w_early && w_m == (16'd1 << PC_IDX)) ? WB : XFER;
   assign w_nxt     = (r_state == IDLE && !w_start) ? IDLE : w_adv;
   assign w_wbytes  = 12'(WORD_BYTES);
   assign w_imm_n   = 12'(w_n) * w_wbytes;
   assign w_imm_start = w_mode == MODE_DB ? w_imm_n : w_mode == MODE_DA ? w_imm_n - w_wbytes
                      : w_mode == MODE_IB ? w_wbytes : 12'd0;
   assign w_unused  = ^{bus.InstrD[31:28], bus.InstrD[22], w_k_vld};
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_idx   <= '0;
      end else if (!bus.StallD) begin
         r_state <= bus.FlushD ? IDLE : w_nxt;
         r_mask  <= bus.FlushD ? 16'd0 : w_m;
         r_idx   <= (bus.FlushD || r_state == IDLE) ? 5'd0 : r_state == XFER ? r_idx + 5'd1 : r_idx;
         if (w_start) begin
            r_n     <= w_n;
            r_rn    <= w_rn;
            r_u     <= bus.InstrD[23];
            r_l     <= bus.InstrD[20];
            r_wb    <= w_wb_i;
            r_early <= w_early_i;
         end
      end
   end
   always_comb begin
      bus.RA1_4b_D     = bus.InstrD[19:16];
      bus.RA2_4b_D     = bus.InstrD[3:0];
      bus.DestRegD     = bus.InstrD[15:12];
      bus.RegFileRzD   = 3'b000;
      bus.UopImmD      = 12'd0;
      bus.UopAddD      = 1'b0;
      bus.UopMemReadD  = 1'b0;
      bus.UopMemWriteD = 1'b0;
      bus.UopRegWriteD = 1'b0;
      bus.UopActiveD   = 1'b0;
      bus.uOpStallD    = w_nxt != IDLE;
      if (r_state == IDLE && w_blk) begin
         bus.RA1_4b_D   = 4'h0;
         bus.RA2_4b_D   = 4'h0;
         bus.DestRegD   = 4'h0;
         bus.UopActiveD = 1'b1;
         if (w_n != 5'd0) begin
            bus.RA1_4b_D     = w_rn;
            bus.DestRegD     = RZ_SEL;
            bus.RegFileRzD   = 3'b100;
            bus.UopImmD      = w_imm_start;
            bus.UopAddD      = bus.InstrD[23];
            bus.UopRegWriteD = 1'b1;
         end
      end else if (r_state == XFER) begin
         bus.RA1_4b_D     = RZ_SEL;
         bus.RA2_4b_D     = r_l ? 4'h0 : w_k;
         bus.DestRegD     = r_l ? w_k : 4'h0;
         bus.RegFileRzD   = 3'b001;
         bus.UopImmD      = 12'(r_idx) * w_wbytes;
         bus.UopAddD      = 1'b1;
         bus.UopMemReadD  = r_l;
         bus.UopMemWriteD = !r_l;
         bus.UopRegWriteD = r_l;
         bus.UopActiveD   = 1'b1;
      end else if (r_state == WB) begin
         bus.RA1_4b_D     = r_rn;
         bus.RA2_4b_D     = 4'h0;
         bus.DestRegD     = r_rn;
         bus.UopImmD      = 12'(r_n) * w_wbytes;
         bus.UopAddD      = r_u;
         bus.UopRegWriteD = 1'b1;
         bus.UopActiveD   = 1'b1;
      end
   end
endmodule

// File: tb/tb_ldmstm_uop_sequencer.sv
// tb_ldmstm_uop_sequencer: directed LDM/STM vectors; expected micro-ops are queued at issue
// and a negedge monitor pops and compares every presented micro-op.
module tb_ldmstm_uop_sequencer;
   typedef struct packed {
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic [3:0]  dest;
      logic [2:0]  rz;
      logic [11:0] imm;
      logic        add;
      logic        rd;
      logic        wr;
      logic        rw;
      logic        stall;
   } uop_t;
   localparam logic [31:0] PASS  = 32'hE0812003;
   localparam logic [31:0] STM8  = 32'hE88300FF;
   localparam logic [31:0] LDM1  = 32'hE8B0000E;
   localparam logic [31:0] EMPTY = 32'hE8900000;
   logic clk = 1'b0;
   logic reset = 1'b0;
   uop_t exp_q[$];
   uop_t mon_g, mon_e;
   int n_vec = 0, n_err = 0, n_uop = 0;
   ldmstm_uop_sequencer_if bus();
   ldmstm_uop_sequencer #(.WORD_BYTES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic uop_t addr(logic [3:0] rn, int imm, logic add, logic s);
      return '{rn, 4'h0, 4'hF, 3'b100, 12'(imm), add, 1'b0, 1'b0, 1'b1, s};
   endfunction
   function automatic uop_t ld(logic [3:0] k, int i, logic s);
      return '{4'hF, 4'h0, k, 3'b001, 12'(4 * i), 1'b1, 1'b1, 1'b0, 1'b1, s};
   endfunction
   function automatic uop_t st(logic [3:0] k, int i, logic s);
      return '{4'hF, k, 4'h0, 3'b001, 12'(4 * i), 1'b1, 1'b0, 1'b1, 1'b0, s};
   endfunction
   function automatic uop_t wbk(logic [3:0] rn, int imm, logic u, logic s);
      return '{rn, 4'h0, rn, 3'b000, 12'(imm), u, 1'b0, 1'b0, 1'b1, s};
   endfunction
   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask
   task automatic issue(logic [31:0] ins, int n);
      bus.InstrD = ins;
      bus.ValidD = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      bus.ValidD = 1'b0;
      bus.InstrD = PASS;
   endtask
   always @(negedge clk) begin
      if (bus.UopActiveD === 1'b1 && bus.StallD === 1'b0) begin
         mon_g = '{bus.RA1_4b_D, bus.RA2_4b_D, bus.DestRegD, bus.RegFileRzD, bus.UopImmD, bus.UopAddD,
                   bus.UopMemReadD, bus.UopMemWriteD, bus.UopRegWriteD, bus.uOpStallD};
         n_vec++;
         n_uop++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL uop%0d unexpected got %h", n_uop, mon_g);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_g !== mon_e) begin
               n_err++;
               $display("FAIL uop%0d got %h exp %h", n_uop, mon_g, mon_e);
            end
         end
      end
   end
   initial begin
      bus.InstrD = PASS;
      bus.ValidD = 1'b0;
      bus.StallD = 1'b0;
      bus.FlushD = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_ra1", 32'(bus.RA1_4b_D), 1);
      chk("rst_ra2", 32'(bus.RA2_4b_D), 3);
      chk("rst_dest", 32'(bus.DestRegD), 2);
      chk("rst_rz", 32'(bus.RegFileRzD), 0);
      chk("rst_active", 32'(bus.UopActiveD), 0);
      chk("rst_stall", 32'(bus.uOpStallD), 0);
      @(posedge clk);
      #1;
      // LDMIA R0!,{R1-R3}
      exp_q.push_back(addr(0, 0, 1, 1));
      exp_q.push_back(ld(1, 0, 1));
      exp_q.push_back(ld(2, 1, 1));
      exp_q.push_back(ld(3, 2, 1));
      exp_q.push_back(wbk(0, 12, 1, 0));
      issue(LDM1, 5);
      // STMDB R13!,{R4,LR}
      exp_q.push_back(addr(13, 8, 0, 1));
      exp_q.push_back(st(4, 0, 1));
      exp_q.push_back(st(14, 1, 1));
      exp_q.push_back(wbk(13, 8, 0, 0));
      issue(32'hE92D4010, 4);
      // LDMIA R1!,{R1,R5}: base in list, writeback suppressed
      exp_q.push_back(addr(1, 0, 1, 1));
      exp_q.push_back(ld(1, 0, 1));
      exp_q.push_back(ld(5, 1, 0));
      issue(32'hE8B10022, 3);
      // LDMIA R2!,{R0,PC}: writeback before the PC load
      exp_q.push_back(addr(2, 0, 1, 1));
      exp_q.push_back(ld(0, 0, 1));
      exp_q.push_back(wbk(2, 8, 1, 1));
      exp_q.push_back(ld(15, 1, 0));
      issue(32'hE8B28001, 4);
      // LDMDA R4,{R1,R2} and LDMIB R5,{R6}
      exp_q.push_back(addr(4, 4, 0, 1));
      exp_q.push_back(ld(1, 0, 1));
      exp_q.push_back(ld(2, 1, 0));
      issue(32'hE8140006, 3);
      exp_q.push_back(addr(5, 4, 1, 1));
      exp_q.push_back(ld(6, 0, 0));
      issue(32'hE9950040, 2);
      // STMIA R3,{R0-R7} with a two-cycle stall on the third transfer
      exp_q.push_back(addr(3, 0, 1, 1));
      for (int k = 0; k < 8; k++) exp_q.push_back(st(4'(k), k, k < 7));
      bus.InstrD = STM8;
      bus.ValidD = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.StallD = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("stall_ra2", 32'(bus.RA2_4b_D), 2);
         chk("stall_imm", 32'(bus.UopImmD), 8);
         @(posedge clk);
      end
      #1 bus.StallD = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      bus.ValidD = 1'b0;
      bus.InstrD = PASS;
      // flush mid-transfer, then reset while the next ADDR is presented
      exp_q.push_back(addr(3, 0, 1, 1));
      exp_q.push_back(st(0, 0, 1));
      exp_q.push_back(st(1, 1, 1));
      exp_q.push_back(st(2, 2, 1));
      bus.InstrD = STM8;
      bus.ValidD = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.FlushD = 1'b1;
      @(posedge clk);
      #1;
      bus.FlushD = 1'b0;
      exp_q.push_back(addr(0, 0, 1, 1));
      bus.InstrD = LDM1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.InstrD = PASS;
      @(negedge clk);
      chk("post_rst_ra1", 32'(bus.RA1_4b_D), 1);
      chk("post_rst_dest", 32'(bus.DestRegD), 2);
      chk("post_rst_active", 32'(bus.UopActiveD), 0);
      chk("post_rst_stall", 32'(bus.uOpStallD), 0);
      @(posedge clk);
      #1;
      exp_q.push_back('0);
      issue(EMPTY, 1);
      repeat (3) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
